// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Lets two clients share one shift-add multiplier datapath. A round-robin
//   arbiter picks a requester, its operands are muxed onto the datapath, and
//   a small FSM sequences the datapath strobes (load, add, decrement, shift)
//   from the datapath status (q0, zero). The product is returned with a
//   one-cycle done pulse. A watchdog flags jobs where zero never arrived.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req0/req1         service requests; held with stable operands until ack
//   a0,b0 / a1,b1     operands of requester 0 / 1
//   ack0/ack1         one-cycle grant; operands are loaded this cycle
//   done0/done1       one-cycle completion pulse per requester
//   result            product of the last completed job, held until the next
//   error             pulses with done when the watchdog expired
//   busy              high whenever the FSM is not idle
//   dp_a, dp_b        operands to the datapath (zero outside the load cycle)
//   load_regs, add_regs, decr_p, shift_regs   datapath strobes
//   q0, zero          datapath multiplier LSB / iteration counter is zero
//   dp_product        datapath product {A,Q}
module mult_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 error,
    output logic                 busy,
    output logic [WIDTH-1:0]     dp_a,
    output logic [WIDTH-1:0]     dp_b,
    output logic                 load_regs,
    output logic                 add_regs,
    output logic                 decr_p,
    output logic                 shift_regs,
    input  logic                 q0,
    input  logic                 zero,
    input  logic [2*WIDTH-1:0]   dp_product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             grant;      // requester owning the current job
    logic             grant_nxt;
    logic             last;       // requester served most recently
    logic [CNT_W-1:0] cnt;        // completed shift iterations
    logic             err;        // watchdog fired for the current job

    // Next-state and arbitration. A tie goes to the requester that was not
    // served last, which makes held requests alternate.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; that is what keeps a latch from being inferred.
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nxt = S_LOAD;
                    grant_nxt = (req0 && req1) ? ~last : req1;
                end
            end
            S_LOAD:  state_nxt = S_ADD;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                // zero has priority; the iteration count is only a watchdog
                if (zero || (cnt == LAST_ITER)) state_nxt = S_DONE;
                else                            state_nxt = S_ADD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            grant  <= 1'b0;
            last   <= 1'b1;      // requester 0 wins the first tie
            cnt    <= '0;
            err    <= 1'b0;
            result <= '0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            error  <= 1'b0;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // only, so every register samples pre-edge values of the others.
            state <= state_nxt;
            grant <= grant_nxt;
            done0 <= 1'b0;
            done1 <= 1'b0;
            error <= 1'b0;
            case (state)
                S_LOAD: begin
                    cnt  <= '0;
                    last <= grant;
                end
                S_SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!zero && (cnt == LAST_ITER)) err <= 1'b1;
                end
                S_DONE: begin
                    result <= dp_product;
                    done0  <= ~grant;
                    done1  <= grant;
                    error  <= err;
                    err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Moore strobes decoded from state; add is qualified by q0 in ADD only.
    assign load_regs  = (state == S_LOAD);
    assign decr_p     = (state == S_ADD);
    assign add_regs   = (state == S_ADD) & q0;
    assign shift_regs = (state == S_SHIFT);
    assign busy       = (state != S_IDLE);
    assign ack0       = load_regs & ~grant;
    assign ack1       = load_regs & grant;

    // Operands reach the datapath only while it is being loaded.
    assign dp_a = load_regs ? (grant ? a1 : a0) : '0;
    assign dp_b = load_regs ? (grant ? b1 : b0) : '0;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a behavioural shift-add datapath feeds q0 /
// zero back to the DUT, and a cycle monitor predicts each cycle's outputs
// from the job timeline (grant by round-robin rule, operand bits, product).
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int WIDTH = 8;
    localparam int W2    = 2 * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic              ack0, ack1, done0, done1, error, busy;
    logic [W2-1:0]     result;
    logic [WIDTH-1:0]  dp_a, dp_b;
    logic              load_regs, add_regs, decr_p, shift_regs;
    logic              q0, zero;
    logic [W2-1:0]     dp_product;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_add    = 0;   // add strobes seen out of reset
    int n_ack    = 0;   // grants seen out of reset
    bit force_zero = 1'b0;

    mult_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .error(error), .busy(busy),
        .dp_a(dp_a), .dp_b(dp_b),
        .load_regs(load_regs), .add_regs(add_regs), .decr_p(decr_p),
        .shift_regs(shift_regs),
        .q0(q0), .zero(zero), .dp_product(dp_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural shift-add datapath ----------------
    logic [WIDTH-1:0] m_acc = '0, m_q = '0, m_m = '0;
    logic             m_c = 1'b0;
    int               m_p = 0;

    always @(posedge clk) begin
        if (load_regs) begin
            m_acc <= '0; m_c <= 1'b0; m_q <= dp_a; m_m <= dp_b; m_p <= WIDTH;
        end else begin
            if (add_regs)   {m_c, m_acc} <= {1'b0, m_acc} + {1'b0, m_m};
            if (decr_p)     m_p <= m_p - 1;
            if (shift_regs) {m_c, m_acc, m_q} <= {1'b0, m_c, m_acc, m_q[WIDTH-1:1]};
        end
    end

    assign q0         = m_q[0];
    assign zero       = force_zero ? 1'b0 : (m_p == 0);
    assign dp_product = {m_acc, m_q};

    // ---------------- cycle monitor / reference model ----------------
    // Job timeline from the grant cycle (phase 0): odd phases are ADD, even
    // phases 2..2W are SHIFT, phase 2W+1 is DONE, phase 2W+2 shows done.
    bit               job_on = 1'b0, job_g = 1'b0, job_err = 1'b0;
    int               job_t = 0, ph = 0;
    logic [WIDTH-1:0] job_a = '0, job_b = '0;
    bit               last_g = 1'b1, prev_idle = 1'b1, idle_now = 1'b1;
    logic [W2-1:0]    exp_result = '0;
    logic [9:0]       got_v, exp_v;
    logic [WIDTH-1:0] exp_da, exp_db;

    always @(negedge clk) begin
        got_v = {load_regs, add_regs, decr_p, shift_regs, busy,
                 ack0, ack1, done0, done1, error};
        if (!rst_n) begin
            check("reset_strobes", 64'(got_v), 64'd0);
            check("reset_data", 64'({dp_a, dp_b, result}), 64'd0);
            job_on = 1'b0; last_g = 1'b1; exp_result = '0; prev_idle = 1'b1;
        end else begin
            if (add_regs) n_add++;
            if (ack0 || ack1) n_ack++;
            exp_v = '0; exp_da = '0; exp_db = '0; idle_now = 1'b1;
            // requests present at the edge that left an idle cycle start a job
            if (prev_idle && (req0 || req1)) begin
                job_on  = 1'b1;
                job_t   = cyc;
                job_g   = (req0 && req1) ? !last_g : req1;
                last_g  = job_g;
                job_a   = job_g ? a1 : a0;
                job_b   = job_g ? b1 : b0;
                job_err = force_zero;
            end
            if (job_on) begin
                ph = cyc - job_t;
                idle_now = 1'b0;
                if (ph == 0) begin
                    exp_v[9] = 1'b1; exp_v[5] = 1'b1;
                    exp_v[job_g ? 3 : 4] = 1'b1;
                    exp_da = job_a; exp_db = job_b;
                end else if (ph <= 2*WIDTH) begin
                    exp_v[5] = 1'b1;
                    if (ph % 2 == 1) begin
                        exp_v[7] = 1'b1;
                        exp_v[8] = job_a[(ph-1)/2];
                    end else begin
                        exp_v[6] = 1'b1;
                    end
                end else if (ph == 2*WIDTH + 1) begin
                    exp_v[5] = 1'b1;
                end else begin
                    exp_v[job_g ? 1 : 2] = 1'b1;
                    exp_v[0] = job_err;
                    exp_result = W2'(job_a) * W2'(job_b);
                    job_on = 1'b0;
                    idle_now = 1'b1;
                end
            end
            check("strobes", 64'(got_v), 64'(exp_v));
            check("dp_operands", 64'({dp_a, dp_b}), 64'({exp_da, exp_db}));
            check("result", 64'(result), 64'(exp_result));
            prev_idle = idle_now;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(output bit g);
        bit ok;
        ok = 1'b0;
        g  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ack0 || ack1) begin
                ok = 1'b1;
                g  = ack1;
                break;
            end
        end
        check("ack_wait", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (done0 || done1) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_wait", 64'(ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit g;
        int n, base, t_prev, r, nreq;

        // 1: reset held with a request pending, then released
        rst_n = 1'b0; req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
        repeat (3) tick();
        check("t1_quiet_in_reset", 64'({ack0, ack1, busy, load_regs}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t1_ack0_next_cycle", 64'(ack0), 64'd1);
        req0 = 1'b0;
        wait_done(n);
        check("t1_latency", 64'(n), 64'd18);
        check("t1_result", 64'(result), 64'd42);

        // 2: single requester, add strobes follow the multiplier bits
        repeat (2) tick();
        base = n_add;
        a0 = 8'd13; b0 = 8'd11; req0 = 1'b1;
        wait_ack(g);
        check("t2_grant", 64'(g), 64'd0);
        req0 = 1'b0;
        wait_done(n);
        check("t2_done0", 64'({done0, done1, error}), 64'b100);
        check("t2_result", 64'(result), 64'd143);
        check("t2_add_count", 64'(n_add - base), 64'd3);

        // 3: simultaneous requests straight after reset, each dropped at ack
        tick();
        rst_n = 1'b0;
        tick();
        base = n_ack;
        a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
        req0 = 1'b1; req1 = 1'b1;
        rst_n = 1'b1;
        wait_ack(g);
        check("t3_first_grant", 64'(g), 64'd0);
        req0 = 1'b0;
        wait_done(n);
        check("t3_result0", 64'({done0, result}), 64'({1'b1, 16'd15}));
        wait_ack(g);
        check("t3_second_grant", 64'(g), 64'd1);
        req1 = 1'b0;
        wait_done(n);
        check("t3_result1", 64'({done1, result}), 64'({1'b1, 16'd63}));
        repeat (25) tick();
        check("t3_no_more_acks", 64'(n_ack - base), 64'd2);

        // 4: both requests held for four jobs: alternating, back-to-back
        req0 = 1'b1; req1 = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(g);
            check("t4_order", 64'(g), 64'(i % 2));
            if (i > 0) check("t4_gap", 64'(cyc - t_prev), 64'd19);
            t_prev = cyc;
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            if (g) begin a1 = 8'($urandom); b1 = 8'($urandom); end
            else   begin a0 = 8'($urandom); b0 = 8'($urandom); end
        end
        wait_done(n);
        check("t4_last_done", 64'({done0, done1}), 64'b01);

        // 5: reset in the third shift discards the job
        repeat (2) tick();
        a0 = 8'd200; b0 = 8'd100; req0 = 1'b1;
        wait_ack(g);
        req0 = 1'b0;
        repeat (6) tick();
        check("t5_in_third_shift", 64'(shift_regs), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_strobes_cleared",
              64'({load_regs, add_regs, decr_p, shift_regs, busy, ack0, ack1, done0}), 64'd0);
        a1 = 8'd255; b1 = 8'd255; req1 = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_ack(g);
        check("t5_grant", 64'(g), 64'd1);
        req1 = 1'b0;
        wait_done(n);
        check("t5_result", 64'({done1, result}), 64'({1'b1, 16'd65025}));

        // 6: zero never arrives -> watchdog error with done
        repeat (2) tick();
        force_zero = 1'b1;
        base = n_add;
        a0 = 8'd0; b0 = 8'($urandom); req0 = 1'b1;
        wait_ack(g);
        req0 = 1'b0;
        wait_done(n);
        check("t6_latency", 64'(n), 64'd18);
        check("t6_done_error", 64'({done0, error, result}), 64'({2'b11, 16'd0}));
        check("t6_no_adds", 64'(n_add - base), 64'd0);
        tick();
        check("t6_error_one_cycle", 64'({error, busy}), 64'd0);
        force_zero = 1'b0;

        // random jobs: random operands, requester sets and occasional watchdog
        for (int it = 0; it < 16; it++) begin
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            force_zero = ($urandom_range(0, 7) == 0);
            r = $urandom_range(1, 3);
            nreq = (r & 1) + (r >> 1);
            req0 = r[0]; req1 = r[1];
            for (int k = 0; k < nreq; k++) begin
                wait_ack(g);
                if (g) req1 = 1'b0;
                else   req0 = 1'b0;
            end
            wait_done(n);
            check("rnd_latency", 64'(n), 64'd18);
            repeat ($urandom_range(0, 3)) tick();
        end
        force_zero = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
